// File: rtl/uart_ctrl.sv
// 8N1 UART with 16x-oversampled receiver, transmitter, automatic echo of every
// received byte and a push-button send path through a one-entry pending buffer.
module uart_ctrl #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic [7:0] tx_din,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       tx_done,
    output logic       tx_busy,
    output logic       tx
);
    localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OW-1:0] T_LAST = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] T_HALF = OW'(OVERSAMPLE / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [CW-1:0] div_q;
    logic          tick;
    logic          rx_meta_q, rx_sync_q;

    assign tick = (div_q == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) div_q <= '0;
        else             div_q <= div_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    logic [1:0]    rx_state_q, rx_state_d;
    logic [OW-1:0] rx_tcnt_q, rx_tcnt_d;
    logic [2:0]    rx_bcnt_q, rx_bcnt_d;
    logic [7:0]    rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic          rx_done_q, rx_done_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bcnt_d  = rx_bcnt_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_done_d  = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = S_START;
                    rx_tcnt_d  = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    // Mid start bit: a line already back high was a glitch
                    if (rx_tcnt_q == T_HALF) begin
                        rx_tcnt_d  = '0;
                        rx_bcnt_d  = '0;
                        rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (rx_tcnt_q == T_LAST) begin
                        rx_tcnt_d  = '0;
                        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                        rx_bcnt_d  = rx_bcnt_q + 1'b1;
                        if (rx_bcnt_q == 3'd7) rx_state_d = S_STOP;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                if (tick) begin
                    if (rx_tcnt_q == T_LAST) begin
                        rx_data_d  = rx_shift_q;
                        rx_done_d  = 1'b1;
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= S_IDLE;
            rx_tcnt_q  <= '0;
            rx_bcnt_q  <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bcnt_q  <= rx_bcnt_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_done_q  <= rx_done_d;
        end
    end

    logic [1:0]    tx_state_q, tx_state_d;
    logic [OW-1:0] tx_tcnt_q, tx_tcnt_d;
    logic [2:0]    tx_bcnt_q, tx_bcnt_d;
    logic [7:0]    tx_shift_q, tx_shift_d, pend_byte_q, pend_byte_d;
    logic          tx_q, tx_d, tx_busy_q, tx_busy_d, tx_done_q, tx_done_d;
    logic          btn_prev_q, pend_valid_q, pend_valid_d;
    logic          req_valid, tx_idle;
    logic [7:0]    req_byte;

    // Echo wins over a same-cycle button edge, which is then lost
    assign req_valid = rx_done_q | (btn_start & ~btn_prev_q);
    assign req_byte  = rx_done_q ? rx_data_q : tx_din;
    assign tx_idle   = (tx_state_q == S_IDLE);

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_tcnt_d    = tx_tcnt_q;
        tx_bcnt_d    = tx_bcnt_q;
        tx_shift_d   = tx_shift_q;
        tx_d         = tx_q;
        tx_busy_d    = tx_busy_q;
        tx_done_d    = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_byte_d  = pend_byte_q;
        case (tx_state_q)
            S_IDLE: begin
                if (pend_valid_q || req_valid) begin
                    tx_state_d = S_START;
                    tx_tcnt_d  = '0;
                    tx_d       = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_shift_d = pend_valid_q ? pend_byte_q : req_byte;
                end
            end
            S_START: begin
                if (tick) begin
                    if (tx_tcnt_q == T_LAST) begin
                        tx_tcnt_d  = '0;
                        tx_bcnt_d  = '0;
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_state_d = S_DATA;
                    end else begin
                        tx_tcnt_d = tx_tcnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (tx_tcnt_q == T_LAST) begin
                        tx_tcnt_d = '0;
                        if (tx_bcnt_q == 3'd7) begin
                            tx_d       = 1'b1;
                            tx_state_d = S_STOP;
                        end else begin
                            tx_bcnt_d  = tx_bcnt_q + 1'b1;
                            tx_d       = tx_shift_q[0];
                            tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        end
                    end else begin
                        tx_tcnt_d = tx_tcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                if (tick) begin
                    if (tx_tcnt_q == T_LAST) begin
                        tx_done_d  = 1'b1;
                        tx_busy_d  = 1'b0;
                        tx_state_d = S_IDLE;
                    end else begin
                        tx_tcnt_d = tx_tcnt_q + 1'b1;
                    end
                end
            end
        endcase
        // Draining the buffer frees it for a request arriving in the same cycle
        if (tx_idle && pend_valid_q) begin
            pend_valid_d = req_valid;
            pend_byte_d  = req_byte;
        end else if (req_valid && !tx_idle && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_byte_d  = req_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q   <= S_IDLE;
            tx_tcnt_q    <= '0;
            tx_bcnt_q    <= '0;
            tx_shift_q   <= '0;
            tx_q         <= 1'b1;
            tx_busy_q    <= 1'b0;
            tx_done_q    <= 1'b0;
            btn_prev_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_byte_q  <= '0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_tcnt_q    <= tx_tcnt_d;
            tx_bcnt_q    <= tx_bcnt_d;
            tx_shift_q   <= tx_shift_d;
            tx_q         <= tx_d;
            tx_busy_q    <= tx_busy_d;
            tx_done_q    <= tx_done_d;
            btn_prev_q   <= btn_start;
            pend_valid_q <= pend_valid_d;
            pend_byte_q  <= pend_byte_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rx_done = rx_done_q;
    assign tx_done = tx_done_q;
    assign tx_busy = tx_busy_q;
    assign tx      = tx_q;
endmodule

// File: tb/tb_uart_ctrl.sv
// Directed/random bench for uart_ctrl at a fast line rate (10 clocks per tick),
// with an independent line decoder and byte queues as the reference.
module tb_uart_ctrl;
    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 10_000;
    localparam int unsigned OVS      = 16;
    localparam int DIV = CLK_FREQ / (BAUD * OVS);
    localparam int BIT = OVS * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] tx_din = 8'h00;
    logic [7:0] rx_data;
    logic       rx_done, tx_done, tx_busy, tx;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rx_done_cnt = 0, tx_done_cnt = 0, tx_frame_err = 0;
    int rx_done_cyc = 0, tx_fall_cyc = 0, start_cyc = 0;
    logic [7:0] rx_got[$], tx_got[$], exp_rx[$], exp_tx[$];

    uart_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVS)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .tx_din(tx_din), .rx(rx),
        .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
        .tx_busy(tx_busy), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            rx_done_cnt++;
            rx_got.push_back(rx_data);
            rx_done_cyc = cyc;
        end
        if (tx_done === 1'b1) tx_done_cnt++;
    end

    // Line-level decoder: samples mid-bit relative to the start-bit edge
    initial begin : tx_decoder
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge tx);
            tx_fall_cyc = cyc;
            repeat (BIT / 2) @(posedge clk);
            #1 ok = (tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(posedge clk);
                #1 b[i] = tx;
            end
            repeat (BIT) @(posedge clk);
            #1 ok = ok & (tx === 1'b1);
            if (!ok) tx_frame_err++;
            tx_got.push_back(b);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic wait_tx_done(input int n, input int limit, input string tag);
        int k = 0;
        while (tx_done_cnt < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(tag, tx_done_cnt, n);
    endtask

    task automatic pulse_btn(input logic [7:0] v);
        @(negedge clk);
        tx_din = v;
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        int busy_cycles, k, n0, done_at_fall;

        @(negedge clk);
        rst = 1'b0;
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_rx_done", rx_done, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_rx_data", rx_data, 8'h00);

        // Single receive of 0x31 and its echo
        exp_rx.push_back(8'h31);
        exp_tx.push_back(8'h31);
        send_byte(8'h31);
        check("rx1_count", rx_done_cnt, 1);
        check("rx1_data", rx_data, 8'h31);
        check("rx1_latency", ((rx_done_cyc - start_cyc) >= 151 * DIV) &&
                             ((rx_done_cyc - start_cyc) <= 153 * DIV), 1);
        wait_tx_done(1, 3 * 10 * BIT, "echo1_done");
        check("echo1_start", ((tx_fall_cyc - rx_done_cyc) >= 0) &&
                             ((tx_fall_cyc - rx_done_cyc) <= DIV + 2), 1);

        // Back-to-back random bytes: all received and all echoed in order
        for (int i = 0; i < 8; i++) begin
            r = 8'($urandom);
            exp_rx.push_back(r);
            exp_tx.push_back(r);
            send_byte(r);
        end
        wait_tx_done(9, 3 * 10 * BIT, "stream_done");
        check("stream_rx_count", rx_done_cnt, 9);
        check("stream_rx_hold", rx_data, exp_rx[8]);

        // Button send with busy-width and tx_done alignment
        exp_tx.push_back(8'hA5);
        @(negedge clk);
        tx_din = 8'hA5;
        btn_start = 1'b1;
        busy_cycles = 0;
        done_at_fall = 0;
        k = 0;
        while (k < 2 * 10 * BIT) begin
            @(negedge clk);
            btn_start = 1'b0;
            k++;
            if (tx_busy === 1'b1) busy_cycles++;
            else if (busy_cycles > 0) begin
                done_at_fall = tx_done;
                break;
            end
        end
        check("btn_busy_width", (busy_cycles > 159 * DIV) && (busy_cycles <= 160 * DIV), 1);
        check("btn_done_at_fall", done_at_fall, 1);
        wait_tx_done(10, 4 * BIT, "btn_done");

        // Starts at once, second is buffered, third is dropped
        exp_tx.push_back(8'h5A);
        exp_tx.push_back(8'hC3);
        pulse_btn(8'h5A);
        pulse_btn(8'hC3);
        pulse_btn(8'h3C);
        wait_tx_done(12, 4 * 10 * BIT, "burst_done");
        repeat (12 * BIT) @(negedge clk);
        check("burst_no_extra", tx_done_cnt, 12);

        // Short low pulse on rx must not produce a byte
        @(negedge clk);
        rx = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        rx = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        check("glitch_no_rx", rx_done_cnt, 9);
        check("glitch_no_tx", tx_busy, 0);
        exp_rx.push_back(8'h96);
        exp_tx.push_back(8'h96);
        send_byte(8'h96);
        check("after_glitch_rx", rx_data, 8'h96);
        wait_tx_done(13, 3 * 10 * BIT, "after_glitch_echo");

        check("rx_queue_size", rx_got.size(), exp_rx.size());
        for (int i = 0; i < exp_rx.size() && i < rx_got.size(); i++)
            check($sformatf("rx_byte%0d", i), rx_got[i], exp_rx[i]);
        check("tx_queue_size", tx_got.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++)
            check($sformatf("tx_byte%0d", i), tx_got[i], exp_tx[i]);
        check("tx_framing", tx_frame_err, 0);

        // Reset in the middle of data bit 4
        n0 = tx_done_cnt;
        pulse_btn(8'h0F);
        repeat (5 * BIT + BIT / 2 - 1) @(negedge clk);
        check("pre_rst_busy", tx_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx", tx, 1);
        check("midrst_busy", tx_busy, 0);
        check("midrst_tx_done", tx_done, 0);
        check("midrst_rx_data", rx_data, 8'h00);
        repeat (8 * BIT) @(negedge clk);
        check("midrst_no_done", tx_done_cnt, n0);
        check("midrst_idle_tx", tx, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
